bus_slave_decoder: RTL and testbench
====================================

Name: bus_slave_decoder

Overview:
- Parametrised, registered successor to the 3-bit one-hot module-select decoder.
- Takes a single-master request (address, write enable, write data) and decodes the top SEL_W address bits to a one-hot slave select.
- Holds the select for the whole transaction, waits for the selected slave's acknowledge, and returns read data to the master.
- Flags unmapped addresses and timeouts with an error response.
- Sits between the control-bus master and up to 2^SEL_W peripheral modules.

Parameters:
- ADDR_W, 16: master address width.
- SEL_W, 3: number of top address bits used as the slave index.
- N_SLV, 8: number of implemented slaves; legal range 1..2^SEL_W.
- DATA_W, 32: data width.
- TIMEOUT, 255: cycles to wait for a slave acknowledge; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  1  master request; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read.
- ADDR  in  ADDR_W  master address.
- WDATA  in  DATA_W  master write data.
- ACK  out  1  one-cycle transaction-done pulse.
- ERR  out  1  valid with ACK; 1 = unmapped address or timeout.
- RDATA  out  DATA_W  read data; valid with ACK.
- BUSY  out  1  high whenever the state is not IDLE.
- SLV_SEL  out  N_SLV  one-hot slave select, registered.
- SLV_ADDR  out  ADDR_W-SEL_W  latched low address bits.
- SLV_WE  out  1  latched write enable.
- SLV_WDATA  out  DATA_W  latched write data.
- SLV_ACK  in  N_SLV  per-slave acknowledge.
- SLV_RDATA  in  N_SLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset: all outputs go to 0 immediately (asynchronous), including SLV_SEL. State = IDLE, timer = 0. Reset mid-transaction aborts it with no ACK.
- Index: idx = ADDR[ADDR_W-1 -: SEL_W], captured together with the low address bits, WE and WDATA on the accepting edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, REQ=1 and idx < N_SLV: latch the request, set SLV_SEL[idx]=1, clear the timer, go to ACCESS. SLV_SEL is visible in the cycle after REQ is sampled.
- IDLE, REQ=1 and idx >= N_SLV: SLV_SEL stays 0. Set ERR=1, RDATA=0, go to RESP. ACK appears one cycle after REQ is sampled.
- ACCESS, SLV_ACK[idx]=1: capture SLV_RDATA slice idx into RDATA (writes also capture it; master ignores it), ERR=0, clear SLV_SEL, go to RESP.
- ACCESS, timeout: when TIMEOUT≠0 and timer==TIMEOUT without an acknowledge, clear SLV_SEL, set ERR=1, RDATA=0, go to RESP.
- ACCESS, otherwise: timer increments, saturating. Timer width is clog2(TIMEOUT+1), minimum 1.
- Acknowledge on the timeout cycle: acknowledge wins; the response is OK.
- RESP: ACK=1 for exactly one cycle with ERR and RDATA valid, then IDLE. ACK and ERR return to 0 in IDLE. RDATA holds its value until the next capture.
- Acknowledges from non-selected slaves are ignored in every state.
- REQ outside IDLE is ignored; it is not queued. The master must hold REQ until it sees BUSY, or re-issue after ACK.
- Back-to-back: a REQ sampled in the IDLE cycle right after RESP is accepted. Minimum mapped transaction: REQ edge, SLV_SEL, slave acknowledges in the same cycle, ACK on the next cycle, i.e. ACK 2 cycles after REQ is sampled.
- SLV_SEL is one-hot or all-zero at every cycle; it is never multi-hot.

Decomposition:
- Shared package (bus_pkg):
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - default widths;
  - a function returning the slave index from an address.
- One sub-module, slave_sel_decode (combinational):
  - generalises the original decoder;
  - inputs: SEL_W-bit index and an enable;
  - outputs: N_SLV one-hot select plus a HIT flag (index < N_SLV).
  - The top level registers its output.

Test Plan:
- Read slave 2, slave acknowledges 3 cycles after SLV_SEL with data 0xDEADBEEF -> SLV_SEL=8'b00000100 for 3 cycles; one ACK pulse with RDATA=0xDEADBEEF and ERR=0; BUSY falls after the ACK cycle.
- N_SLV=5, ADDR=0xA000 (idx 5) -> SLV_SEL stays 0; ACK=1 and ERR=1 one cycle after REQ; RDATA=0.
- TIMEOUT=4, slave never acknowledges -> SLV_SEL high for 5 cycles, then ACK=1, ERR=1.
- Write to slave 7 with WDATA=0x12345678, slave 3 acknowledges spuriously, then slave 7 acknowledges -> spurious acknowledge ignored; SLV_WE=1, SLV_WDATA=0x12345678 stable until the slave 7 acknowledge; ERR=0.
- RST asserted while in ACCESS -> SLV_SEL, BUSY and ACK are 0 immediately, before the next edge; no ACK after release; next REQ proceeds normally.
- REQ held high for 4 consecutive transactions with immediate acknowledges -> exactly one ACK per transaction; one IDLE cycle between transactions; SLV_SEL never multi-hot.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared state encoding, default widths and address-to-index helper for the
// control-bus slave decoder.
package bus_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_SEL_W   = 3;
   localparam int DEF_N_SLV   = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

   // Upper bounds for the width-agnostic index helper below
   localparam int MAX_ADDR_W = 64;
   localparam int MAX_SEL_W  = 8;

   // Returns the top sel_w bits of an addr_w-bit address, right-aligned.
   function automatic logic [MAX_SEL_W-1:0] slv_idx(
      input logic [MAX_ADDR_W-1:0] addr,
      input int                    addr_w,
      input int                    sel_w
   );
      logic [MAX_ADDR_W-1:0] shifted;
      logic [MAX_ADDR_W-1:0] mask;
      shifted = addr >> (addr_w - sel_w);
      mask    = (64'd1 << sel_w) - 64'd1;
      return MAX_SEL_W'(shifted & mask);
   endfunction

endpackage

// File: rtl/slave_sel_decode.sv
// Combinational index-to-one-hot decoder with an in-range flag; generalises
// the original fixed 3-bit module-select decoder.
module slave_sel_decode #(
   parameter int SEL_W = 3,
   parameter int N_SLV = 8
) (
   input  logic [SEL_W-1:0] idx,
   input  logic             en,
   output logic [N_SLV-1:0] sel,
   output logic             hit
);

   for (genvar i = 0; i < N_SLV; i++) begin : g_sel
      assign sel[i] = en && (idx == SEL_W'(i));
   end

   // Indices at or above N_SLV decode to no slave; the caller turns that into an error
   assign hit = (32'(idx) < 32'(N_SLV));

endmodule

// File: rtl/bus_slave_decoder.sv
// Registered single-master to multi-slave control-bus decoder: holds the one-hot
// select for the whole access, waits for the slave acknowledge, returns data/error.
module bus_slave_decoder
   import bus_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int SEL_W   = DEF_SEL_W,
   parameter int N_SLV   = DEF_N_SLV,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    REQ,
   input  logic                    WE,
   input  logic [ADDR_W-1:0]       ADDR,
   input  logic [DATA_W-1:0]       WDATA,
   output logic                    ACK,
   output logic                    ERR,
   output logic [DATA_W-1:0]       RDATA,
   output logic                    BUSY,
   output logic [N_SLV-1:0]        SLV_SEL,
   output logic [ADDR_W-SEL_W-1:0] SLV_ADDR,
   output logic                    SLV_WE,
   output logic [DATA_W-1:0]       SLV_WDATA,
   input  logic [N_SLV-1:0]        SLV_ACK,
   input  logic [N_SLV*DATA_W-1:0] SLV_RDATA
);

   localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LO_W  = ADDR_W - SEL_W;

   if (N_SLV < 1 || N_SLV > (1 << SEL_W)) begin : g_bad_nslv
      $error("bus_slave_decoder: N_SLV out of range for SEL_W");
   end

   logic [1:0]        state;
   logic [TMR_W-1:0]  timer;
   logic [SEL_W-1:0]  req_idx;
   logic [N_SLV-1:0]  dec_sel;
   logic              dec_hit;
   logic              dec_en;
   logic              ack_hit;
   logic              tmo;
   logic [DATA_W-1:0] sel_rdata;

   assign req_idx = SEL_W'(slv_idx(MAX_ADDR_W'(ADDR), ADDR_W, SEL_W));
   assign dec_en  = REQ && (state == ST_IDLE);

   slave_sel_decode #(
      .SEL_W (SEL_W),
      .N_SLV (N_SLV)
   ) u_dec (
      .idx (req_idx),
      .en  (dec_en),
      .sel (dec_sel),
      .hit (dec_hit)
   );

   // Masking with the registered select makes acks from other slaves invisible
   assign ack_hit = |(SLV_ACK & SLV_SEL);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (SLV_SEL[i]) sel_rdata = sel_rdata | SLV_RDATA[i*DATA_W +: DATA_W];
      end
   end

   assign tmo  = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT));
   assign BUSY = (state != ST_IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         timer     <= '0;
         ACK       <= 1'b0;
         ERR       <= 1'b0;
         RDATA     <= '0;
         SLV_SEL   <= '0;
         SLV_ADDR  <= '0;
         SLV_WE    <= 1'b0;
         SLV_WDATA <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (REQ) begin
                  if (dec_hit) begin
                     SLV_SEL   <= dec_sel;
                     SLV_ADDR  <= ADDR[LO_W-1:0];
                     SLV_WE    <= WE;
                     SLV_WDATA <= WDATA;
                     timer     <= '0;
                     state     <= ST_ACCESS;
                  end else begin
                     ERR   <= 1'b1;
                     RDATA <= '0;
                     ACK   <= 1'b1;
                     state <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               // Acknowledge is tested first so it wins on the timeout cycle
               if (ack_hit) begin
                  RDATA   <= sel_rdata;
                  ERR     <= 1'b0;
                  ACK     <= 1'b1;
                  SLV_SEL <= '0;
                  state   <= ST_RESP;
               end else if (tmo) begin
                  RDATA   <= '0;
                  ERR     <= 1'b1;
                  ACK     <= 1'b1;
                  SLV_SEL <= '0;
                  state   <= ST_RESP;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end
            ST_RESP: begin
               ACK   <= 1'b0;
               ERR   <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               ACK     <= 1'b0;
               ERR     <= 1'b0;
               SLV_SEL <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_slave_decoder.sv
// Scoreboard bench: driver pushes expected {ERR,RDATA} per request, a negedge
// monitor pops on every ACK; slaves are modelled by the driver with random latency.
module tb_bus_slave_decoder;

   localparam int AW  = 16;
   localparam int SW  = 3;
   localparam int N   = 6;
   localparam int DW  = 32;
   localparam int TMO = 6;

   logic            CLK, RST, REQ, WE;
   logic [AW-1:0]   ADDR;
   logic [DW-1:0]   WDATA;
   logic            ACK, ERR, BUSY;
   logic [DW-1:0]   RDATA;
   logic [N-1:0]    SLV_SEL;
   logic [AW-SW-1:0] SLV_ADDR;
   logic            SLV_WE;
   logic [DW-1:0]   SLV_WDATA;
   logic [N-1:0]    SLV_ACK;
   logic [N*DW-1:0] SLV_RDATA;

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   bus_slave_decoder #(
      .ADDR_W (AW), .SEL_W (SW), .N_SLV (N), .DATA_W (DW), .TIMEOUT (TMO)
   ) dut (
      .CLK (CLK), .RST (RST), .REQ (REQ), .WE (WE), .ADDR (ADDR), .WDATA (WDATA),
      .ACK (ACK), .ERR (ERR), .RDATA (RDATA), .BUSY (BUSY),
      .SLV_SEL (SLV_SEL), .SLV_ADDR (SLV_ADDR), .SLV_WE (SLV_WE),
      .SLV_WDATA (SLV_WDATA), .SLV_ACK (SLV_ACK), .SLV_RDATA (SLV_RDATA)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: one expected response per ACK pulse; select must never be multi-hot
   always @(negedge CLK) begin
      if (!RST) begin
         chk("sel_onehot", 64'((SLV_SEL & (SLV_SEL - 1'b1)) != '0), 64'd0);
         if (ACK) begin
            if (sbq.size() == 0) begin
               chk("unexpected_ack", 64'(ACK), 64'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("resp_err", 64'(ERR), 64'(e.err));
               chk("resp_rdata", 64'(RDATA), 64'(e.rdata));
            end
         end
      end
   end

   // One full transaction; d = ACCESS cycle in which the slave acks (> TMO: never)
   task automatic txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                      input int d, input logic [DW-1:0] data, input logic spur_all);
      int         idx;
      exp_t       e;
      logic [N-1:0] m;
      idx     = int'(addr[AW-1 -: SW]);
      e.err   = (idx >= N) || (d > TMO);
      e.rdata = e.err ? '0 : data;
      sbq.push_back(e);
      REQ = 1'b1; WE = we; ADDR = addr; WDATA = wdata;
      @(posedge CLK); #1;
      REQ = 1'b0;
      chk("busy_after_req", 64'(BUSY), 64'd1);
      if (idx >= N) begin
         chk("unmapped_sel", 64'(SLV_SEL), 64'd0);
         chk("unmapped_ack", 64'(ACK), 64'd1);
         @(posedge CLK); #1;
      end else begin
         m = N'(1) << idx;
         chk("sel_onehot_idx", 64'(SLV_SEL), 64'(m));
         chk("slv_addr", 64'(SLV_ADDR), 64'(addr[AW-SW-1:0]));
         chk("slv_we", 64'(SLV_WE), 64'(we));
         chk("slv_wdata", 64'(SLV_WDATA), 64'(wdata));
         for (int k = 0; k <= TMO; k++) begin
            SLV_ACK = spur_all ? ~m : (N'($urandom) & ~m);
            if (k == d) SLV_ACK = SLV_ACK | m;
            for (int s = 0; s < N; s++) SLV_RDATA[s*DW +: DW] = $urandom;
            SLV_RDATA[idx*DW +: DW] = data;
            @(posedge CLK); #1;
            SLV_ACK = '0;
            if (k == d || k == TMO) break;
            chk("sel_held", 64'(SLV_SEL), 64'(m));
            chk("no_early_ack", 64'(ACK), 64'd0);
            chk("wdata_stable", 64'(SLV_WDATA), 64'(wdata));
            chk("we_stable", 64'(SLV_WE), 64'(we));
         end
         chk("resp_ack", 64'(ACK), 64'd1);
         chk("resp_sel_clear", 64'(SLV_SEL), 64'd0);
         @(posedge CLK); #1;
      end
      chk("idle_busy", 64'(BUSY), 64'd0);
      chk("idle_ack", 64'(ACK), 64'd0);
   endtask

   initial begin
      RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0;
      SLV_ACK = '0; SLV_RDATA = '0;
      #1;
      chk("rst_ack", 64'(ACK), 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_sel", 64'(SLV_SEL), 64'd0);
      chk("rst_rdata", 64'(RDATA), 64'd0);
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      @(posedge CLK); #1;

      // Directed cases
      txn(16'h4000, 1'b0, '0, 3, 32'hDEADBEEF, 1'b0);        // read slave 2
      txn(16'hC000, 1'b0, '0, 0, 32'h11111111, 1'b0);        // idx 6 unmapped
      txn(16'hE123, 1'b1, 32'h5, 0, 32'h22222222, 1'b0);     // idx 7 unmapped
      txn(16'h2010, 1'b0, '0, TMO + 1, 32'h33333333, 1'b0);  // timeout
      txn(16'h0044, 1'b0, '0, TMO, 32'h44444444, 1'b0);      // ack on timeout cycle wins
      txn(16'hA0F0, 1'b1, 32'h12345678, 2, 32'h55555555, 1'b1); // write slave 5, spurious acks
      txn(16'h6000, 1'b0, '0, 0, 32'h66666666, 1'b0);        // minimum latency

      // Reset mid-ACCESS aborts without an ACK
      REQ = 1'b1; WE = 1'b0; ADDR = 16'h4000;
      @(posedge CLK); #1;
      REQ = 1'b0;
      @(posedge CLK); #2;
      RST = 1'b1;
      #1;
      chk("rst_mid_sel", 64'(SLV_SEL), 64'd0);
      chk("rst_mid_busy", 64'(BUSY), 64'd0);
      chk("rst_mid_ack", 64'(ACK), 64'd0);
      @(posedge CLK); #2;
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         chk("post_rst_ack", 64'(ACK), 64'd0);
         chk("post_rst_busy", 64'(BUSY), 64'd0);
      end
      txn(16'h8ABC, 1'b0, '0, 1, 32'h77777777, 1'b0);

      // REQ held high, immediate acks: one transaction every 3 cycles
      for (int s = 0; s < N; s++) SLV_RDATA[s*DW +: DW] = 32'hB0B0_0000 + 32'(s);
      for (int t = 0; t < 4; t++) begin
         exp_t e;
         e.err = 1'b0; e.rdata = 32'hB0B0_0001;
         sbq.push_back(e);
      end
      REQ = 1'b1; ADDR = 16'h2000; WE = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(posedge CLK); #1;
         chk("b2b_ack", 64'(ACK), 64'(i % 3 == 1));
         SLV_ACK = SLV_SEL;
         if (i == 10) REQ = 1'b0;
      end
      @(posedge CLK); #1;
      SLV_ACK = '0;
      chk("b2b_idle", 64'(BUSY), 64'd0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         txn(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, TMO + 2)),
             $urandom, 1'b0);
      end

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge CLK);
      #1;
      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
